// File: rtl/seg_scan_mux.sv
// Four-digit seven-segment scan multiplexer for a common-anode display.
// It blanks between digit slots and samples its inputs once per refresh frame.
module seg_scan_mux #(
  parameter int SCAN_DIVIDE  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        blank_leading,
  input  logic [3:0]  digit_enable,
  output logic [3:0]  digit_select,
  output logic [6:0]  seg
);

  localparam int CW = (SCAN_DIVIDE > 2) ? $clog2(SCAN_DIVIDE) : 1;
  localparam logic [CW-1:0] POS_LAST   = CW'(SCAN_DIVIDE - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } state_t;

  // With no blanking gap configured, every slot opens directly in SHOW.
  localparam state_t SLOT_START = (BLANK_CYCLES > 0) ? ST_BLANK : ST_SHOW;

  // pos_q/digit_q/state_q describe the position the next rising edge will
  // display, so each output register lands on the edge that owns its position.
  logic [CW-1:0] pos_q, pos_d;
  logic [1:0]    digit_q, digit_d;
  state_t        state_q, state_d;

  logic [15:0]   snap_value_q;
  logic          snap_blank_q;
  logic [3:0]    snap_enable_q;

  logic          frame_start;
  logic [15:0]   cur_value;
  logic          cur_blank;
  logic [3:0]    cur_enable;
  logic [3:0]    nibble;
  logic          upper_zero;
  logic          dark;
  logic [3:0]    select_d;
  logic [6:0]    seg_d;

  function automatic logic [6:0] decode(input logic [3:0] hex);
    logic [6:0] pattern;
    unique case (hex)
      4'h0: pattern = 7'b1000000;
      4'h1: pattern = 7'b1111001;
      4'h2: pattern = 7'b0100100;
      4'h3: pattern = 7'b0110000;
      4'h4: pattern = 7'b0011001;
      4'h5: pattern = 7'b0010010;
      4'h6: pattern = 7'b0000010;
      4'h7: pattern = 7'b1111000;
      4'h8: pattern = 7'b0000000;
      4'h9: pattern = 7'b0010000;
      4'ha: pattern = 7'b0001000;
      4'hb: pattern = 7'b0000011;
      4'hc: pattern = 7'b1000110;
      4'hd: pattern = 7'b0100001;
      4'he: pattern = 7'b0000110;
      default: pattern = 7'b0001110;
    endcase
    return pattern;
  endfunction

  // The first slot of a frame decodes the inputs being captured on that same
  // edge; every later slot of the frame reads only the snapshot.
  always_comb begin
    frame_start = (pos_q == '0) && (digit_q == 2'd0);
    cur_value   = frame_start ? value         : snap_value_q;
    cur_blank   = frame_start ? blank_leading : snap_blank_q;
    cur_enable  = frame_start ? digit_enable  : snap_enable_q;
  end

  // NOTE: every always_comb output gets a default first so no path through
  // the case statements can leave a value held, which would infer a latch.
  always_comb begin
    nibble     = cur_value[{digit_q, 2'b00} +: 4];
    upper_zero = 1'b0;
    unique case (digit_q)
      2'd1:    upper_zero = (cur_value[15:4]  == 12'h000);
      2'd2:    upper_zero = (cur_value[15:8]  == 8'h00);
      2'd3:    upper_zero = (cur_value[15:12] == 4'h0);
      default: upper_zero = 1'b0;
    endcase
    dark = !cur_enable[digit_q] || (cur_blank && upper_zero);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BLANK: if (pos_q == BLANK_LAST) state_d = ST_SHOW;
      ST_SHOW:  if (pos_q == POS_LAST)   state_d = SLOT_START;
      default:  state_d = SLOT_START;
    endcase

    if (pos_q == POS_LAST) begin
      pos_d   = '0;
      digit_d = digit_q + 2'd1;
    end else begin
      pos_d   = pos_q + 1'b1;
      digit_d = digit_q;
    end

    select_d = 4'b1111;
    seg_d    = 7'b1111111;
    if (state_q == ST_SHOW && !dark) begin
      select_d = ~(4'b0001 << digit_q);
      seg_d    = decode(nibble);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      pos_q         <= '0;
      digit_q       <= 2'd0;
      state_q       <= SLOT_START;
      snap_value_q  <= 16'h0000;
      snap_blank_q  <= 1'b0;
      snap_enable_q <= 4'b0000;
      digit_select  <= 4'b1111;
      seg           <= 7'b1111111;
    end else begin
      pos_q        <= pos_d;
      digit_q      <= digit_d;
      state_q      <= state_d;
      digit_select <= select_d;
      seg          <= seg_d;
      if (frame_start) begin
        snap_value_q  <= value;
        snap_blank_q  <= blank_leading;
        snap_enable_q <= digit_enable;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomised and directed bench for seg_scan_mux, checked every cycle against
// a position-arithmetic model of the display (frame = 4 slots of SCAN_DIVIDE).
module tb_seg_scan_mux;

  localparam int SD = 10;
  localparam int BC = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = 16'h0000;
  logic        blank_leading = 1'b0;
  logic [3:0]  digit_enable = 4'b0000;
  logic [3:0]  digit_select;
  logic [6:0]  seg;

  seg_scan_mux #(.SCAN_DIVIDE(SD), .BLANK_CYCLES(BC)) dut (
    .clock        (clock),
    .reset        (reset),
    .value        (value),
    .blank_leading(blank_leading),
    .digit_enable (digit_enable),
    .digit_select (digit_select),
    .seg          (seg)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Segment patterns for hex digits 0..F, active-low gfedcba.
  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Model: absolute time since reset release, frame snapshot, expected outputs.
  int          m_t = 0;
  int          cur_t = -1;
  bit          model_valid = 1'b0;
  logic [15:0] s_value;
  logic        s_blank;
  logic [3:0]  s_enable;
  logic [3:0]  exp_select;
  logic [6:0]  exp_seg;

  always @(posedge clock) begin
    if (reset) begin
      m_t = 0;
      cur_t = -1;
      s_value = 16'h0;
      s_blank = 1'b0;
      s_enable = 4'h0;
      exp_select = 4'b1111;
      exp_seg = 7'b1111111;
      model_valid = 1'b1;
    end else if (model_valid) begin
      int p, d;
      bit dk, allz;
      if (m_t % (4 * SD) == 0) begin
        s_value = value;
        s_blank = blank_leading;
        s_enable = digit_enable;
      end
      p = m_t % SD;
      d = (m_t / SD) % 4;
      dk = !s_enable[d];
      if (s_blank && d > 0) begin
        allz = 1'b1;
        for (int k = d; k < 4; k++)
          if (s_value[4*k +: 4] != 4'h0) allz = 1'b0;
        if (allz) dk = 1'b1;
      end
      if (p >= BC && !dk) begin
        exp_select = 4'b1111;
        exp_select[d] = 1'b0;
        exp_seg = seg_tab[s_value[4*d +: 4]];
      end else begin
        exp_select = 4'b1111;
        exp_seg = 7'b1111111;
      end
      cur_t = m_t;
      m_t++;
    end
  end

  // Per-cycle comparison, sampled on the falling edge.
  always @(negedge clock) begin
    if (model_valid) begin
      check("digit_select", 32'(digit_select), 32'(exp_select));
      check("seg", 32'(seg), 32'(exp_seg));
      check("one_anode", 32'($countones(~digit_select) <= 1), 32'd1);
    end
  end

  task automatic wait_t(input int n);
    bit hit = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (cur_t == n) begin
        hit = 1'b1;
        break;
      end
    end
    check("wait_t_timeout", 32'(hit), 32'd1);
  endtask

  task automatic pin(input string name, input logic [3:0] sel, input logic [6:0] sg);
    check({name, "_sel"}, 32'(digit_select), 32'(sel));
    check({name, "_seg"}, 32'(seg), 32'(sg));
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clock);
    reset = 1'b1;
    repeat (cycles) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    // Reset held 5 cycles, then the 1234 frame.
    repeat (5) @(negedge clock);
    pin("reset_state", 4'b1111, 7'b1111111);
    value = 16'h1234;
    blank_leading = 1'b0;
    digit_enable = 4'b1111;
    reset = 1'b0;
    wait_t(0);  pin("t0_blank", 4'b1111, 7'b1111111);
    wait_t(2);  pin("d0_4", 4'b1110, 7'b0011001);
    wait_t(12); pin("d1_3", 4'b1101, 7'b0110000);
    wait_t(22); pin("d2_2", 4'b1011, 7'b0100100);
    wait_t(32); pin("d3_1", 4'b0111, 7'b1111001);
    wait_t(40); pin("wrap_blank", 4'b1111, 7'b1111111);
    wait_t(42); pin("wrap_d0", 4'b1110, 7'b0011001);

    // Mid-frame reset pulse at t=17.
    do_reset(1);
    wait_t(17);
    reset = 1'b1;
    @(negedge clock);
    pin("midframe_reset", 4'b1111, 7'b1111111);
    value = 16'h0042;
    blank_leading = 1'b1;
    reset = 1'b0;
    wait_t(2);  pin("lz_d0_2", 4'b1110, 7'b0100100);
    wait_t(12); pin("lz_d1_4", 4'b1101, 7'b0011001);
    wait_t(22); pin("lz_d2_dark", 4'b1111, 7'b1111111);
    wait_t(35); value = 16'h0000;
    wait_t(42); pin("zero_d0", 4'b1110, 7'b1000000);
    wait_t(52); pin("zero_d1_dark", 4'b1111, 7'b1111111);

    // Snapshot isolation: change 1111 -> ABCD mid-frame.
    do_reset(2);
    value = 16'h1111;
    blank_leading = 1'b0;
    digit_enable = 4'b1111;
    wait_t(15); value = 16'hABCD;
    wait_t(32); pin("old_frame_1", 4'b0111, 7'b1111001);
    wait_t(42); pin("new_d", 4'b1110, 7'b0100001);
    wait_t(52); pin("new_c", 4'b1101, 7'b1000110);
    wait_t(62); pin("new_b", 4'b1011, 7'b0000011);
    wait_t(72); pin("new_a", 4'b0111, 7'b0001000);

    // Digit enables 0101 over 8 frames.
    do_reset(1);
    value = 16'h8888;
    digit_enable = 4'b0101;
    wait_t(2);  pin("en_d0", 4'b1110, 7'b0000000);
    wait_t(12); pin("en_d1_dark", 4'b1111, 7'b1111111);
    wait_t(22); pin("en_d2", 4'b1011, 7'b0000000);
    wait_t(32); pin("en_d3_dark", 4'b1111, 7'b1111111);
    wait_t(8 * 4 * SD);

    // Random inputs with occasional reset pulses; the model checks every cycle.
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if ($urandom_range(0, 7) == 0) begin
        value = 16'($urandom);
        if ($urandom_range(0, 1) == 1) value = value & 16'h00FF;
        if ($urandom_range(0, 3) == 0) value = value & 16'h000F;
      end
      if ($urandom_range(0, 15) == 0) blank_leading = 1'($urandom);
      if ($urandom_range(0, 15) == 0) digit_enable = 4'($urandom);
      reset = ($urandom_range(0, 499) == 0);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
